// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC core arbiter: default sizes, the tag
// width helper and the in-flight pipeline entry type.
package cordic_arb_pkg;

  localparam int DEF_LAT   = 16;
  localparam int DEF_DW    = 32;
  // Widest tag ever needed (NREQ <= 8); narrower builds zero-extend into it.
  localparam int MAX_TAG_W = 3;

  // $clog2 returns 0 for a single requester; a tag still needs one bit.
  function automatic int TAG_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One stage of the ownership pipeline that shadows the core.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } pipe_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index starting at the
// pointer and wrapping modulo N. Produces a one-hot-or-zero grant plus the
// binary index of the winner. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [TW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [TW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Walk ptr, ptr+1, ... and latch onto the first eligible requester.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && eligible_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = TW'(j);
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one fixed-latency pipelined vectoring CORDIC core between NREQ
// requesters. A round-robin arbiter issues at most one operand per cycle,
// a valid/tag shift pipeline remembers who owns each operand in flight, and
// per-requester credit counters cap outstanding work at MAX_OUT.
// Optional build macro CORDIC_ARB_PERF_EN adds saturating perf_issue and
// perf_stall counters as extra outputs.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LAT     = DEF_LAT,
  parameter int MAX_OUT = 4,
  parameter int DW      = DEF_DW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [DW-1:0]      core_in,
  input  logic [DW-1:0]      core_out,
`ifdef CORDIC_ARB_PERF_EN
  output logic [31:0]        perf_issue,
  output logic [31:0]        perf_stall,
`endif
  output logic               busy
);

  localparam int TW = TAG_W(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [TW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        credit_q [NREQ];
  logic [CW-1:0]        credit_d [NREQ];
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      grant;
  logic [TW-1:0]        grant_idx;
  logic                 fire;
  logic [DW-1:0]        core_in_q, core_in_d;
  pipe_entry_t          stage0_d;
  logic [LAT:0]         vld_q;
  logic [MAX_TAG_W-1:0] tag_q [0:LAT];

  // A requester competes only while it has an operand and spare credit.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (credit_q[i] < CW'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N  (NREQ),
    .TW (TW)
  ) u_rr (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .idx_o      (grant_idx),
    .any_o      (fire)
  );

  assign req_ready = grant;

  // Next issue state: operand, stage-0 entry and the advanced pointer.
  always_comb begin
    core_in_d      = core_in_q;
    rr_ptr_d       = rr_ptr_q;
    stage0_d.valid = fire;
    stage0_d.tag   = MAX_TAG_W'(grant_idx);
    if (fire) begin
      core_in_d = req_data[grant_idx*DW +: DW];
      rr_ptr_d  = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Issue registers and the valid half of the ownership pipeline.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with <= so every register samples pre-edge
    // values; = here would let later statements see this cycle's updates.
    if (reset) begin
      core_in_q <= '0;
      rr_ptr_q  <= '0;
      vld_q     <= '0;
    end else begin
      core_in_q <= core_in_d;
      rr_ptr_q  <= rr_ptr_d;
      vld_q     <= {vld_q[LAT-1:0], stage0_d.valid};
    end
  end

  // Tag half of the ownership pipeline, shifted alongside the valids.
  always_ff @(posedge clock) begin
    // NOTE: tags carry no reset; a tag is only looked at when its valid bit
    // is set, and the valids are cleared by reset.
    tag_q[0] <= stage0_d.tag;
    for (int k = 1; k <= LAT; k++) begin
      tag_q[k] <= tag_q[k-1];
    end
  end

  assign core_in  = core_in_q;
  assign rsp_data = core_out;
  assign busy     = |vld_q;

  // Stage LAT lines up with core_out: route the result to its owner.
  always_comb begin
    rsp_valid = '0;
    if (vld_q[LAT]) begin
      rsp_valid[tag_q[LAT][TW-1:0]] = 1'b1;
    end
  end

  // Credits rise on issue and fall on response; both at once cancel.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      credit_d[i] = credit_q[i];
      case ({grant[i], rsp_valid[i]})
        2'b10:   credit_d[i] = credit_q[i] + CW'(1);
        2'b01:   credit_d[i] = credit_q[i] - CW'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Credit registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) credit_q[i] <= credit_d[i];
    end
  end

`ifdef CORDIC_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;
  logic        stall;

  // Someone wants the core but nobody is granted: all are out of credit.
  assign stall = (|req_valid) && !fire;

  // Saturating handshake and credit-stall counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter. A stand-in core delays core_in by
// LAT cycles and scrambles it with a fixed key. The reference model keeps a
// queue of outstanding operations (owner, data, due cycle); a requester's
// credit is simply how many of its operations are still in that queue.
module tb_cordic_arbiter;

  localparam int NREQ    = 4;
  localparam int LAT     = 16;
  localparam int MAX_OUT = 2;
  localparam int DW      = 32;
  localparam logic [DW-1:0] CORE_KEY = 32'hA5A5_5A5A;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [DW-1:0]      core_in;
  logic [DW-1:0]      core_out;
  logic               busy;
`ifdef CORDIC_ARB_PERF_EN
  logic [31:0]        perf_issue;
  logic [31:0]        perf_stall;
`endif

  cordic_arbiter #(
    .NREQ    (NREQ),
    .LAT     (LAT),
    .MAX_OUT (MAX_OUT),
    .DW      (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .core_in   (core_in),
    .core_out  (core_out),
`ifdef CORDIC_ARB_PERF_EN
    .perf_issue (perf_issue),
    .perf_stall (perf_stall),
`endif
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in core: fixed latency, never reset, no handshake.
  logic [DW-1:0] core_pipe [1:LAT];
  always @(posedge clock) begin
    for (int k = LAT; k > 1; k--) core_pipe[k] <= core_pipe[k-1];
    core_pipe[1] <= core_in;
  end
  assign core_out = core_pipe[LAT] ^ CORE_KEY;

  // Reference model state.
  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            due;
  } op_t;

  op_t           q[$];
  int            rr;
  int            cyc;
  logic [DW-1:0] exp_core_in;
  int            m_issue;
  int            m_stall;
  int            errors;
  int            checks;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [NREQ*DW-1:0] rnd_data();
    logic [NREQ*DW-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d);
    int            outst [NREQ];
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] exp_rsp;
    int            gi;
    int            j;
    req_valid = v;
    req_data  = d;
    #1;
    foreach (outst[i]) outst[i] = 0;
    foreach (q[k]) outst[q[k].tag]++;
    exp_g = '0;
    gi    = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (rr + k) % NREQ;
      if (gi < 0 && v[j] && outst[j] < MAX_OUT) begin
        gi       = j;
        exp_g[j] = 1'b1;
      end
    end
    check("req_ready", req_ready, exp_g);
    exp_rsp = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rsp[q[0].tag] = 1'b1;
      check("rsp_data", rsp_data, q[0].data ^ CORE_KEY);
    end
    check("rsp_valid", rsp_valid, exp_rsp);
    check("busy", busy, q.size() > 0);
    check("core_in", core_in, exp_core_in);
    if (exp_rsp != '0) void'(q.pop_front());
    if (gi >= 0) begin
      q.push_back('{tag: gi, data: d[gi*DW +: DW], due: cyc + LAT + 1});
      rr = (gi + 1) % NREQ;
      m_issue++;
    end else if (|v) begin
      m_stall++;
    end
    @(posedge clock);
    cyc++;
    if (gi >= 0) exp_core_in = d[gi*DW +: DW];
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  task automatic check_perf();
`ifdef CORDIC_ARB_PERF_EN
    check("perf_issue", perf_issue, 32'(m_issue));
    check("perf_stall", perf_stall, 32'(m_stall));
`endif
  endtask

  initial begin
    logic [NREQ*DW-1:0] d;
    errors      = 0;
    checks      = 0;
    rr          = 0;
    cyc         = 0;
    m_issue     = 0;
    m_stall     = 0;
    exp_core_in = '0;
    reset       = 1'b1;
    req_valid   = '0;
    req_data    = '0;

    // Reset state.
    #1;
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_core_in", core_in, '0);
    check("rst_req_ready", req_ready, '0);
    check_perf();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single request from requester 2 at cycle 10.
    while (cyc < 10) step('0, '0);
    d = rnd_data();
    d[2*DW +: DW] = 32'h3F80_0000;
    step(4'b0100, d);
    idle(LAT + 3);

    // Round robin: everyone requesting for 8 cycles.
    repeat (8) step(4'b1111, rnd_data());
    idle(LAT + 3);
    check_perf();

    // Credit limit: only requester 1, continuously.
    repeat (40) step(4'b0010, rnd_data());
    check_perf();
    idle(LAT + 3);

    // Requester 0 fills its credit, then 0 and 3 compete.
    repeat (2) step(4'b0001, rnd_data());
    repeat (4) step(4'b1001, rnd_data());
    idle(LAT + 3);

    // Random mix.
    repeat (80) step(NREQ'($urandom), rnd_data());
    idle(LAT + 3);
    check_perf();

    // Reset in the middle of five in-flight operations.
    repeat (5) step(4'b1111, rnd_data());
    req_valid = 4'b1111;
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_core_in", core_in, '0);
    check("midrst_req_ready", req_ready, 4'b0001);
    q.delete();
    rr          = 0;
    exp_core_in = '0;
    m_issue     = 0;
    m_stall     = 0;
    check_perf();
    @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    reset     = 1'b0;
    idle(LAT + 2);
    step(4'b1000, rnd_data());
    idle(LAT + 3);
    check_perf();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
